// File: rtl/can_bus_model_if.sv
// Signal bundle between CAN controller benches and the shared-bus model.
// The model side takes the slave modport; stimulus/controllers take master.
interface can_bus_model_if #(
  parameter int NODES  = 4,
  parameter int FLEN_W = 8,
  parameter int CNT_W  = 16
);
  logic [NODES-1:0]  tx_i;
  logic [NODES-1:0]  stby_i;
  logic [NODES-1:0]  rx_o;
  logic              bus_o;
  logic [NODES-1:0]  dom_to_o;
  logic [1:0]        fault_mode_i;
  logic [FLEN_W-1:0] fault_len_i;
  logic              fault_trig_i;
  logic              fault_act_o;
  logic              cnt_clr_i;
  logic [CNT_W-1:0]  edge_cnt_o;

  modport master (
    output tx_i, stby_i, fault_mode_i, fault_len_i, fault_trig_i, cnt_clr_i,
    input  rx_o, bus_o, dom_to_o, fault_act_o, edge_cnt_o
  );

  modport slave (
    input  tx_i, stby_i, fault_mode_i, fault_len_i, fault_trig_i, cnt_clr_i,
    output rx_o, bus_o, dom_to_o, fault_act_o, edge_cnt_o
  );
endinterface

// File: rtl/can_bus_model.sv
// Cycle-based wired-AND CAN bus shared by NODES transceivers, with standby,
// rx delay line, TXD dominant timeout, fault window and edge counter.
//
// Fault window FSM:
//   state    | meaning
//   F_IDLE   | no fault window, fcnt = 0, waiting for fault_trig_i
//   F_ACTIVE | window running, fcnt counts remaining faulted bus samples
module can_bus_model #(
  parameter int NODES       = 4,
  parameter int DELAY       = 2,
  parameter int DOM_TIMEOUT = 1024,
  parameter int FLEN_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic            aclk,
  input  logic            arst,
  can_bus_model_if.slave  io
);

  localparam int TCNT_W = $clog2(DOM_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TO_VAL  = TCNT_W'(DOM_TIMEOUT);
  localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(DOM_TIMEOUT - 1);

  typedef enum logic {
    F_IDLE,
    F_ACTIVE
  } fstate_t;

  fstate_t           fstate;
  fstate_t           fstate_nxt;
  logic [FLEN_W-1:0] fcnt;
  logic [FLEN_W-1:0] fcnt_nxt;
  logic              fault_act;

  logic [NODES-1:0]  drv;
  logic              raw;
  logic              res;
  logic              bus_q;
  logic              rx_src;
  logic [NODES-1:0]  dom_to_q;
  logic [TCNT_W-1:0] tcnt [NODES];
  logic [CNT_W-1:0]  edge_cnt;

  // A timed-out node releases its driver exactly like a recessive TXD.
  assign drv = io.tx_i | io.stby_i | dom_to_q;
  assign raw = &drv;

  always_comb begin
    res = raw;
    if (fault_act) begin
      case (io.fault_mode_i)
        2'b01:   res = 1'b0;
        2'b10:   res = 1'b1;
        2'b11:   res = ~raw;
        default: res = raw;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      bus_q <= 1'b1;
    end else begin
      bus_q <= res;
    end
  end

  generate
    if (DELAY == 0) begin : g_nodly
      assign rx_src = bus_q;
    end else begin : g_dly
      logic [DELAY-1:0] dly;

      always_ff @(posedge aclk) begin
        if (arst) begin
          dly <= '1;
        end else begin
          dly[0] <= bus_q;
          for (int k = 1; k < DELAY; k++) begin
            dly[k] <= dly[k-1];
          end
        end
      end

      assign rx_src = dly[DELAY-1];
    end
  endgenerate

  // Standby forces rx recessive without waiting for the delay line.
  assign io.rx_o = io.stby_i | {NODES{rx_src}};

  always_ff @(posedge aclk) begin
    if (arst) begin
      dom_to_q <= '0;
      for (int i = 0; i < NODES; i++) begin
        tcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NODES; i++) begin
        if (io.tx_i[i] || io.stby_i[i]) begin
          tcnt[i]     <= '0;
          dom_to_q[i] <= 1'b0;
        end else if (tcnt[i] < TO_VAL) begin
          tcnt[i] <= tcnt[i] + 1'b1;
          if (tcnt[i] == TO_LAST) begin
            dom_to_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign io.dom_to_o = dom_to_q;

  always_ff @(posedge aclk) begin
    if (arst) begin
      fstate <= F_IDLE;
      fcnt   <= '0;
    end else begin
      fstate <= fstate_nxt;
      fcnt   <= fcnt_nxt;
    end
  end

  // Triggers arriving while a window is running are dropped on purpose.
  always_comb begin
    fstate_nxt = fstate;
    fcnt_nxt   = fcnt;
    case (fstate)
      F_IDLE: begin
        if (io.fault_trig_i && (io.fault_len_i != '0)) begin
          fstate_nxt = F_ACTIVE;
          fcnt_nxt   = io.fault_len_i;
        end
      end
      F_ACTIVE: begin
        fcnt_nxt = fcnt - 1'b1;
        if (fcnt == FLEN_W'(1)) begin
          fstate_nxt = F_IDLE;
        end
      end
      default: begin
        fstate_nxt = F_IDLE;
        fcnt_nxt   = '0;
      end
    endcase
  end

  assign fault_act      = (fstate == F_ACTIVE);
  assign io.fault_act_o = fault_act;

  always_ff @(posedge aclk) begin
    if (arst) begin
      edge_cnt <= '0;
    end else if (io.cnt_clr_i) begin
      edge_cnt <= '0;
    end else if (!res && bus_q && (edge_cnt != '1)) begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  assign io.edge_cnt_o = edge_cnt;
  assign io.bus_o      = bus_q;

endmodule

// File: tb/tb_can_bus_model.sv
// Directed bench for can_bus_model: latency, arbitration, dominant timeout,
// fault window, standby and reset, with hand-computed expectations.
module tb_can_bus_model;

  localparam int NODES  = 4;
  localparam int FLEN_W = 8;
  localparam int CNT_W  = 16;

  logic aclk;
  logic arst;
  int   total;
  int   bad;

  can_bus_model_if #(.NODES(NODES), .FLEN_W(FLEN_W), .CNT_W(CNT_W)) bus_if ();

  can_bus_model #(
    .NODES(NODES),
    .DELAY(2),
    .DOM_TIMEOUT(16),
    .FLEN_W(FLEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk),
    .arst(arst),
    .io(bus_if)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] arb_n0;
  logic [3:0] arb_n1;
  logic [3:0] arb_exp;

  initial begin
    total = 0;
    bad   = 0;
    aclk  = 1'b0;
    arst  = 1'b1;
    bus_if.tx_i         = 4'hF;
    bus_if.stby_i       = 4'h0;
    bus_if.fault_mode_i = 2'b00;
    bus_if.fault_len_i  = 8'd0;
    bus_if.fault_trig_i = 1'b0;
    bus_if.cnt_clr_i    = 1'b0;

    tick();
    tick();
    arst = 1'b0;
    tick();
    chk("rst_bus", 32'(bus_if.bus_o), 32'h1);
    chk("rst_rx", 32'(bus_if.rx_o), 32'hF);
    chk("rst_edge", 32'(bus_if.edge_cnt_o), 32'h0);
    chk("rst_domto", 32'(bus_if.dom_to_o), 32'h0);
    chk("rst_fact", 32'(bus_if.fault_act_o), 32'h0);
    tick();
    tick();
    chk("idle_bus", 32'(bus_if.bus_o), 32'h1);

    // node 2 dominant for 5 cycles: bus low after edges 1..5, rx low 3..7
    bus_if.tx_i = 4'b1011;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("n2_bus_c%0d", c), 32'(bus_if.bus_o), (c <= 5) ? 32'h0 : 32'h1);
      chk($sformatf("n2_rx_c%0d", c), 32'(bus_if.rx_o), (c >= 3 && c <= 7) ? 32'h0 : 32'hF);
      if (c == 5) bus_if.tx_i = 4'hF;
    end
    chk("n2_edge", 32'(bus_if.edge_cnt_o), 32'h1);

    // arbitration: node0 1,0,1,1 vs node1 1,1,0,1
    arb_n0  = 4'b1101;
    arb_n1  = 4'b1011;
    arb_exp = 4'b1001;
    for (int s = 0; s < 4; s++) begin
      bus_if.tx_i = {2'b11, arb_n1[s], arb_n0[s]};
      tick();
      chk($sformatf("arb_bus_s%0d", s), 32'(bus_if.bus_o), 32'(arb_exp[s]));
    end
    bus_if.tx_i = 4'hF;
    tick();
    chk("arb_edge", 32'(bus_if.edge_cnt_o), 32'h2);

    // node 1 stuck dominant for 30 cycles, timeout after 16
    bus_if.tx_i = 4'b1101;
    for (int c = 1; c <= 30; c++) begin
      tick();
      chk($sformatf("to_flag_c%0d", c), 32'(bus_if.dom_to_o), (c >= 16) ? 32'h2 : 32'h0);
      chk($sformatf("to_bus_c%0d", c), 32'(bus_if.bus_o), (c <= 16) ? 32'h0 : 32'h1);
    end
    bus_if.tx_i = 4'hF;
    tick();
    chk("to_clear", 32'(bus_if.dom_to_o), 32'h0);
    chk("to_bus_end", 32'(bus_if.bus_o), 32'h1);
    chk("to_edge", 32'(bus_if.edge_cnt_o), 32'h3);

    // clear wins over a simultaneous falling edge
    bus_if.tx_i      = 4'b1110;
    bus_if.cnt_clr_i = 1'b1;
    tick();
    chk("clr_bus", 32'(bus_if.bus_o), 32'h0);
    chk("clr_edge", 32'(bus_if.edge_cnt_o), 32'h0);
    bus_if.cnt_clr_i = 1'b0;
    bus_if.tx_i      = 4'hF;
    tick();
    chk("clr_edge_hold", 32'(bus_if.edge_cnt_o), 32'h0);
    tick();
    tick();

    // zero-length trigger stays idle
    bus_if.fault_mode_i = 2'b11;
    bus_if.fault_len_i  = 8'd0;
    bus_if.fault_trig_i = 1'b1;
    tick();
    chk("f0_act", 32'(bus_if.fault_act_o), 32'h0);
    bus_if.fault_trig_i = 1'b0;
    tick();
    chk("f0_bus", 32'(bus_if.bus_o), 32'h1);

    // invert fault, length 3, retrigger one cycle later is ignored
    bus_if.fault_len_i  = 8'd3;
    bus_if.fault_trig_i = 1'b1;
    tick();
    chk("finv_act_k", 32'(bus_if.fault_act_o), 32'h1);
    chk("finv_bus_k", 32'(bus_if.bus_o), 32'h1);
    tick();
    bus_if.fault_trig_i = 1'b0;
    chk("finv_act_k1", 32'(bus_if.fault_act_o), 32'h1);
    chk("finv_bus_k1", 32'(bus_if.bus_o), 32'h0);
    tick();
    chk("finv_act_k2", 32'(bus_if.fault_act_o), 32'h1);
    chk("finv_bus_k2", 32'(bus_if.bus_o), 32'h0);
    tick();
    chk("finv_act_k3", 32'(bus_if.fault_act_o), 32'h0);
    chk("finv_bus_k3", 32'(bus_if.bus_o), 32'h0);
    tick();
    chk("finv_act_k4", 32'(bus_if.fault_act_o), 32'h0);
    chk("finv_bus_k4", 32'(bus_if.bus_o), 32'h1);
    chk("finv_edge", 32'(bus_if.edge_cnt_o), 32'h1);
    bus_if.fault_mode_i = 2'b00;
    tick();
    tick();

    // standby node cannot pull the bus and sees recessive immediately
    bus_if.tx_i   = 4'b0111;
    bus_if.stby_i = 4'b1000;
    #1;
    chk("stby_rx_now", 32'(bus_if.rx_o), 32'hF);
    tick();
    chk("stby_bus", 32'(bus_if.bus_o), 32'h1);
    chk("stby_rx", 32'(bus_if.rx_o), 32'hF);

    // stuck-dominant fault, then reset in the middle of the window
    bus_if.fault_mode_i = 2'b01;
    bus_if.fault_len_i  = 8'd10;
    bus_if.fault_trig_i = 1'b1;
    tick();
    bus_if.fault_trig_i = 1'b0;
    tick();
    chk("sd_bus", 32'(bus_if.bus_o), 32'h0);
    chk("sd_act", 32'(bus_if.fault_act_o), 32'h1);
    arst = 1'b1;
    tick();
    chk("mrst_bus", 32'(bus_if.bus_o), 32'h1);
    chk("mrst_rx", 32'(bus_if.rx_o), 32'hF);
    chk("mrst_act", 32'(bus_if.fault_act_o), 32'h0);
    chk("mrst_edge", 32'(bus_if.edge_cnt_o), 32'h0);
    chk("mrst_domto", 32'(bus_if.dom_to_o), 32'h0);
    arst = 1'b0;
    bus_if.fault_mode_i = 2'b00;
    bus_if.stby_i       = 4'h0;
    bus_if.tx_i         = 4'hF;
    tick();
    chk("post_bus", 32'(bus_if.bus_o), 32'h1);
    chk("post_act", 32'(bus_if.fault_act_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
